// File: rtl/vr_commit_eng.sv
// Commit engine for a view-stamped replica: parses a commit message and issues
// one log "apply" request per op number until the committed op number catches up.
package vr_commit_eng_pkg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;

endpackage

module vr_commit_eng
  import vr_commit_eng_pkg::*;
#(
  parameter int NOC_DATA_W     = -1,
  parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
  parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      manage_commit_msg_val,
  input  udp_info                   manage_commit_pkt_info,
  output logic                      commit_manage_msg_rdy,

  input  logic                      manage_commit_req_val,
  input  logic [NOC_DATA_W-1:0]     manage_commit_req,
  input  logic                      manage_commit_req_last,
  input  logic [NOC_PADBYTES_W-1:0] manage_commit_req_padbytes,
  output logic                      commit_manage_req_rdy,

  input  logic [63:0]               curr_view,
  input  logic                      curr_view_normal,

  output logic                      commit_log_req_val,
  output logic [63:0]               commit_log_req_opnum,
  input  logic                      log_commit_req_rdy,

  output logic [63:0]               commit_opnum,
  output logic                      commit_eng_rdy,
  output logic [15:0]               drop_cnt
);

  // Width used for header extraction; equals NOC_DATA_W in any legal build.
  localparam int DW = (NOC_DATA_W < 128) ? 128 : NOC_DATA_W;

  typedef enum logic [2:0] {IDLE, HDR, DRAIN, CHECK, APPLY} state_t;

  state_t      state, state_nxt;
  logic [DW-1:0] beat;
  logic [63:0] beat_view, beat_opnum;
  logic [15:0] len_q;
  logic [63:0] view_q, opnum_q, target_q, opnum_inc;
  logic        msg_hs, beat_hs, log_hs, drop;
  logic        unused_bits;

  assign beat       = DW'(manage_commit_req);
  assign beat_view  = beat[DW-1 -: 64];
  assign beat_opnum = beat[DW-65 -: 64];

  // Padding, trailing payload and the remaining UDP fields carry no meaning here.
  assign unused_bits = ^{beat, manage_commit_req_padbytes, manage_commit_pkt_info};

  assign msg_hs    = manage_commit_msg_val && commit_manage_msg_rdy;
  assign beat_hs   = manage_commit_req_val && commit_manage_req_rdy;
  assign log_hs    = commit_log_req_val && log_commit_req_rdy;
  assign opnum_inc = commit_opnum + 64'd1;

  assign drop = (len_q < 16'd16) || !curr_view_normal ||
                (view_q != curr_view) || (opnum_q <= commit_opnum);

  // The request opnum is derived from commit_opnum, which only moves on a
  // handshake, so it is stable for as long as the request is pending.
  assign commit_log_req_opnum = opnum_inc;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt             = state;
    commit_manage_msg_rdy = 1'b0;
    commit_manage_req_rdy = 1'b0;
    commit_log_req_val    = 1'b0;
    commit_eng_rdy        = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by rst_n so nothing upstream sees ready while reset is held.
        commit_manage_msg_rdy = rst_n;
        commit_eng_rdy        = rst_n;
        if (msg_hs) state_nxt = HDR;
      end
      HDR: begin
        commit_manage_req_rdy = 1'b1;
        if (beat_hs) state_nxt = manage_commit_req_last ? CHECK : DRAIN;
      end
      DRAIN: begin
        commit_manage_req_rdy = 1'b1;
        if (beat_hs && manage_commit_req_last) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = drop ? IDLE : APPLY;
      end
      APPLY: begin
        commit_log_req_val = 1'b1;
        if (log_hs && (opnum_inc == target_q)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      commit_opnum <= '0;
      drop_cnt     <= '0;
      len_q        <= '0;
      view_q       <= '0;
      opnum_q      <= '0;
      target_q     <= '0;
    end else begin
      state <= state_nxt;
      if (msg_hs) len_q <= manage_commit_pkt_info.data_length;
      if ((state == HDR) && beat_hs) begin
        view_q  <= beat_view;
        opnum_q <= beat_opnum;
      end
      if (state == CHECK) begin
        if (drop) begin
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          target_q <= opnum_q;
        end
      end
      if (log_hs) commit_opnum <= opnum_inc;
    end
  end

endmodule

// File: tb/tb_vr_commit_eng.sv
// Directed self-checking bench for vr_commit_eng with a 128-bit beat.
module tb_vr_commit_eng;
  import vr_commit_eng_pkg::*;

  localparam int DW  = 128;
  localparam int PB  = DW / 8;
  localparam int PBW = $clog2(PB);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           msg_val;
  udp_info        info;
  logic           msg_rdy;
  logic           req_val;
  logic [DW-1:0]  req_data;
  logic           req_last;
  logic [PBW-1:0] req_pad;
  logic           req_rdy;
  logic [63:0]    curr_view;
  logic           normal;
  logic           log_val;
  logic [63:0]    log_opnum;
  logic           log_rdy;
  logic [63:0]    commit_opnum;
  logic           eng_rdy;
  logic [15:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] log_op[$];
  int          log_cyc[$];
  int          cyc = 0;
  int          beat_cnt = 0;
  int          last_beat_cyc = 0;
  int          msg_cyc;

  vr_commit_eng #(.NOC_DATA_W(DW), .NOC_PADBYTES(PB), .NOC_PADBYTES_W(PBW)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .manage_commit_msg_val      (msg_val),
    .manage_commit_pkt_info     (info),
    .commit_manage_msg_rdy      (msg_rdy),
    .manage_commit_req_val      (req_val),
    .manage_commit_req          (req_data),
    .manage_commit_req_last     (req_last),
    .manage_commit_req_padbytes (req_pad),
    .commit_manage_req_rdy      (req_rdy),
    .curr_view                  (curr_view),
    .curr_view_normal           (normal),
    .commit_log_req_val         (log_val),
    .commit_log_req_opnum       (log_opnum),
    .log_commit_req_rdy         (log_rdy),
    .commit_opnum               (commit_opnum),
    .commit_eng_rdy             (eng_rdy),
    .drop_cnt                   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && log_val && log_rdy) begin
      log_op.push_back(log_opnum);
      log_cyc.push_back(cyc);
    end
    if (rst_n && req_val && req_rdy) begin
      beat_cnt      <= beat_cnt + 1;
      last_beat_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_commit(input logic [63:0] view, input logic [63:0] opnum,
                             input logic [15:0] len, input int nbeats);
    int guard;
    @(negedge clk);
    info             = '0;
    info.data_length = len;
    msg_val          = 1'b1;
    guard            = 0;
    while (!msg_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!msg_rdy) check("msg_rdy_timeout", 64'(msg_rdy), 64'd1);
    msg_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    msg_val = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      req_val  = 1'b1;
      req_data = (b == 0) ? {view, opnum} : {64'hDEAD_BEEF_0000_0000 | 64'(b), 64'hFFFF_FFFF_FFFF_FFFF};
      req_last = (b == nbeats - 1);
      guard    = 0;
      while (!req_rdy && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!req_rdy) check("req_rdy_timeout", 64'(req_rdy), 64'd1);
      @(posedge clk);
      @(negedge clk);
    end
    req_val  = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (!eng_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 64'(eng_rdy), 64'd1);
  endtask

  task automatic wait_val(input string tag);
    int guard = 0;
    while (!log_val && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 64'(log_val), 64'd1);
  endtask

  initial begin
    int n;
    int b0;
    rst_n = 1'b0; msg_val = 1'b0; info = '0; req_val = 1'b0; req_data = '0;
    req_last = 1'b0; req_pad = '0; curr_view = 64'd5; normal = 1'b1; log_rdy = 1'b1;

    #12;
    check("rst_msg_rdy", 64'(msg_rdy), 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_log_val", 64'(log_val), 64'd0);
    check("rst_commit_opnum", commit_opnum, 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_eng_rdy", 64'(eng_rdy), 64'd1);
    check("post_rst_msg_rdy", 64'(msg_rdy), 64'd1);

    // Single-beat commit catches up from 0 to 3.
    n = log_op.size();
    send_commit(64'd5, 64'd3, 16'd16, 1);
    wait_idle("t1_idle");
    check("t1_req_count", 64'(log_op.size() - n), 64'd3);
    if (log_op.size() >= n + 3) begin
      check("t1_op0", log_op[n], 64'd1);
      check("t1_op1", log_op[n+1], 64'd2);
      check("t1_op2", log_op[n+2], 64'd3);
      check("t1_latency", 64'(log_cyc[n] - msg_cyc), 64'd3);
      check("t1_back_to_back", 64'(log_cyc[n+2] - log_cyc[n]), 64'd2);
    end
    check("t1_commit_opnum", commit_opnum, 64'd3);

    // Wrong view.
    n = log_op.size();
    send_commit(64'd4, 64'd9, 16'd16, 1);
    wait_idle("t2_idle");
    check("t2_no_req", 64'(log_op.size() - n), 64'd0);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t2_commit_opnum", commit_opnum, 64'd3);

    // Stale and equal op numbers.
    send_commit(64'd5, 64'd2, 16'd16, 1);
    wait_idle("t3a_idle");
    send_commit(64'd5, 64'd3, 16'd16, 1);
    wait_idle("t3b_idle");
    check("t3_no_req", 64'(log_op.size() - n), 64'd0);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd3);
    check("t3_commit_opnum", commit_opnum, 64'd3);

    // Body too short, then replica not NORMAL.
    send_commit(64'd5, 64'd5, 16'd15, 1);
    wait_idle("t3c_idle");
    check("t3c_short_drop", 64'(drop_cnt), 64'd4);
    normal = 1'b0;
    send_commit(64'd5, 64'd5, 16'd16, 1);
    wait_idle("t3d_idle");
    normal = 1'b1;
    check("t3d_abnormal_drop", 64'(drop_cnt), 64'd5);
    check("t3d_no_req", 64'(log_op.size() - n), 64'd0);

    // Three-beat body, request only after the last beat.
    b0 = beat_cnt;
    send_commit(64'd5, 64'd4, 16'd40, 3);
    wait_idle("t4_idle");
    check("t4_beats", 64'(beat_cnt - b0), 64'd3);
    check("t4_req_count", 64'(log_op.size() - n), 64'd1);
    if (log_op.size() > n) begin
      check("t4_op", log_op[n], 64'd4);
      check("t4_after_last", 64'(log_cyc[n] - last_beat_cyc), 64'd2);
    end
    check("t4_commit_opnum", commit_opnum, 64'd4);

    // Log stalls 10 cycles; view change during APPLY must not abort.
    log_rdy = 1'b0;
    send_commit(64'd5, 64'd5, 16'd16, 1);
    wait_val("t5_val_seen");
    curr_view = 64'd9;
    normal    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t5_val_hold", 64'(log_val), 64'd1);
      check("t5_opnum_hold", log_opnum, 64'd5);
      check("t5_eng_busy", 64'(eng_rdy), 64'd0);
      @(negedge clk);
    end
    log_rdy = 1'b1;
    wait_idle("t5_idle");
    check("t5_commit_opnum", commit_opnum, 64'd5);
    check("t5_last_op", log_op[$], 64'd5);
    curr_view = 64'd5;
    normal    = 1'b1;

    // Body beat offered while IDLE is not accepted.
    @(negedge clk);
    b0       = beat_cnt;
    req_val  = 1'b1;
    req_last = 1'b1;
    req_data = {64'd5, 64'd99};
    check("t6_idle_req_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("t6_idle_no_beat", 64'(beat_cnt - b0), 64'd0);
    check("t6_still_idle", 64'(eng_rdy), 64'd1);
    req_val  = 1'b0;
    req_last = 1'b0;

    // Asynchronous reset in the middle of APPLY at commit_opnum 7.
    log_rdy = 1'b0;
    send_commit(64'd5, 64'd10, 16'd16, 1);
    wait_val("t7_val_seen");
    log_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    log_rdy = 1'b0;
    check("t7_pre_rst_opnum", commit_opnum, 64'd7);
    check("t7_pre_rst_req", log_opnum, 64'd8);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_opnum", commit_opnum, 64'd0);
    check("t7_rst_val", 64'(log_val), 64'd0);
    check("t7_rst_msg_rdy", 64'(msg_rdy), 64'd0);
    check("t7_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_idle_eng_rdy", 64'(eng_rdy), 64'd1);
    check("t7_idle_msg_rdy", 64'(msg_rdy), 64'd1);
    check("t7_idle_val", 64'(log_val), 64'd0);

    log_rdy = 1'b1;
    n = log_op.size();
    send_commit(64'd5, 64'd1, 16'd16, 1);
    wait_idle("t8_idle");
    check("t8_req_count", 64'(log_op.size() - n), 64'd1);
    check("t8_commit_opnum", commit_opnum, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
